// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: reservation-station request bus plus FU issue port of the issue scheduler.
// master is the scheduler side, slave is the stations/FU side.
interface issue_scheduler_if #(
    parameter int NUM_RS = 4,
    parameter int SLOT_W = 3,
    parameter int TAG_W  = 5
);
    logic [NUM_RS-1:0]        req_valid;
    logic [NUM_RS*SLOT_W-1:0] req_slot;
    logic [NUM_RS*4-1:0]      req_op;
    logic [NUM_RS*7-1:0]      req_opcode;
    logic [NUM_RS*32-1:0]     req_vj;
    logic [NUM_RS*32-1:0]     req_vk;
    logic [NUM_RS*32-1:0]     req_imm;
    logic [NUM_RS*TAG_W-1:0]  req_rob_tag;
    logic [NUM_RS-1:0]        execute_clear;
    logic [NUM_RS*SLOT_W-1:0] execute_slot;
    logic                     fu_valid;
    logic                     fu_ready;
    logic [3:0]               fu_op;
    logic [6:0]               fu_opcode;
    logic [31:0]              fu_vj;
    logic [31:0]              fu_vk;
    logic [31:0]              fu_imm;
    logic [TAG_W-1:0]         fu_rob_tag;

    modport master (
        input  req_valid, req_slot, req_op, req_opcode, req_vj, req_vk, req_imm, req_rob_tag, fu_ready,
        output execute_clear, execute_slot, fu_valid, fu_op, fu_opcode, fu_vj, fu_vk, fu_imm, fu_rob_tag
    );

    modport slave (
        output req_valid, req_slot, req_op, req_opcode, req_vj, req_vk, req_imm, req_rob_tag, fu_ready,
        input  execute_clear, execute_slot, fu_valid, fu_op, fu_opcode, fu_vj, fu_vk, fu_imm, fu_rob_tag
    );
endinterface

// File: rtl/issue_scheduler.sv
// issue_scheduler: round-robin grant of one FU issue port among NUM_RS stations into a single-entry issue register.
// Define ISSUE_SCHED_PERF_EN to add perf_issue_cnt/perf_stall_cnt counters.
module issue_scheduler #(
    parameter int NUM_RS = 4,
    parameter int SLOT_W = 3,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    issue_scheduler_if.master bus
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    localparam int PTR_W = NUM_RS > 1 ? $clog2(NUM_RS) : 1;

    logic [PTR_W-1:0] rr_q, rr_d, gnt_idx, cand;
    logic             gnt, accept, fu_valid_q, fu_valid_d;
    logic [3:0]       op_q;
    logic [6:0]       opcode_q;
    logic [31:0]      vj_q, vk_q, imm_q;
    logic [TAG_W-1:0] tag_q;

    assign accept = !fu_valid_q || bus.fu_ready;

    // Scan downward so the station closest to rr_q wins.
    always_comb begin
        gnt = 1'b0;
        gnt_idx = '0;
        cand = '0;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(rr_q) + k) % NUM_RS);
            if (bus.req_valid[cand]) begin
                gnt = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = gnt && accept && !flush && rst_n;
        rr_d = gnt ? PTR_W'((int'(gnt_idx) + 1) % NUM_RS) : rr_q;
        fu_valid_d = gnt || (fu_valid_q && !flush && !bus.fu_ready);
    end

    always_comb begin
        bus.execute_clear = '0;
        bus.execute_slot = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (gnt && gnt_idx == PTR_W'(i)) begin
                bus.execute_clear[i] = 1'b1;
                bus.execute_slot[i*SLOT_W +: SLOT_W] = bus.req_slot[i*SLOT_W +: SLOT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= '0;
            fu_valid_q <= 1'b0;
            op_q <= '0;
            opcode_q <= '0;
            vj_q <= '0;
            vk_q <= '0;
            imm_q <= '0;
            tag_q <= '0;
        end else begin
            rr_q <= rr_d;
            fu_valid_q <= fu_valid_d;
            if (gnt) begin
                op_q <= bus.req_op[int'(gnt_idx)*4 +: 4];
                opcode_q <= bus.req_opcode[int'(gnt_idx)*7 +: 7];
                vj_q <= bus.req_vj[int'(gnt_idx)*32 +: 32];
                vk_q <= bus.req_vk[int'(gnt_idx)*32 +: 32];
                imm_q <= bus.req_imm[int'(gnt_idx)*32 +: 32];
                tag_q <= bus.req_rob_tag[int'(gnt_idx)*TAG_W +: TAG_W];
            end
        end
    end

    assign bus.fu_valid = fu_valid_q;
    assign bus.fu_op = op_q;
    assign bus.fu_opcode = opcode_q;
    assign bus.fu_vj = vj_q;
    assign bus.fu_vk = vk_q;
    assign bus.fu_imm = imm_q;
    assign bus.fu_rob_tag = tag_q;

`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_q + {31'b0, gnt};
            stall_cnt_q <= stall_cnt_q + {31'b0, |bus.req_valid && !gnt};
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed and random stimulus against a queue-free reference model of the issue scheduler.
module tb_issue_scheduler;
    localparam int N = 4;
    localparam int SW = 3;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    issue_scheduler_if #(.NUM_RS(N), .SLOT_W(SW), .TAG_W(TW)) bus ();

`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
    logic [31:0] m_issue = '0;
    logic [31:0] m_stall = '0;
`endif

    issue_scheduler #(.NUM_RS(N), .SLOT_W(SW), .TAG_W(TW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus)
`ifdef ISSUE_SCHED_PERF_EN
        ,
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Model state: issue register contents and the round-robin start point.
    logic           m_valid = 1'b0;
    logic [111:0]   m_pay = '0;
    int             m_rr = 0;
    logic [111:0]   s_pay[N];
    logic [SW-1:0]  s_slot[N];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic fl, input logic rn);
        int g;
        logic [N-1:0] exp_clear;
        logic [N*SW-1:0] exp_slot;
        @(negedge clk);
        rst_n = rn;
        flush = fl;
        bus.fu_ready = rdy;
        bus.req_valid = v;
        for (int i = 0; i < N; i++) begin
            s_pay[i] = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
            s_slot[i] = SW'($urandom());
            bus.req_slot[i*SW +: SW] = s_slot[i];
            bus.req_op[i*4 +: 4] = s_pay[i][111:108];
            bus.req_opcode[i*7 +: 7] = s_pay[i][107:101];
            bus.req_vj[i*32 +: 32] = s_pay[i][100:69];
            bus.req_vk[i*32 +: 32] = s_pay[i][68:37];
            bus.req_imm[i*32 +: 32] = s_pay[i][36:5];
            bus.req_rob_tag[i*TW +: TW] = s_pay[i][4:0];
        end
        #1;
        g = -1;
        if ((!m_valid || rdy) && !fl && rn)
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
        exp_clear = '0;
        exp_slot = '0;
        if (g >= 0) begin
            exp_clear[g] = 1'b1;
            exp_slot[g*SW +: SW] = s_slot[g];
        end
        check("execute_clear", 128'(bus.execute_clear), 128'(exp_clear));
        check("execute_slot", 128'(bus.execute_slot), 128'(exp_slot));
        check("fu_valid", 128'(bus.fu_valid), 128'(m_valid));
        check("payload", 128'({bus.fu_op, bus.fu_opcode, bus.fu_vj, bus.fu_vk, bus.fu_imm, bus.fu_rob_tag}), 128'(m_pay));
`ifdef ISSUE_SCHED_PERF_EN
        check("perf_issue_cnt", 128'(perf_issue_cnt), 128'(m_issue));
        check("perf_stall_cnt", 128'(perf_stall_cnt), 128'(m_stall));
`endif
        @(posedge clk);
        if (!rn) begin
            m_valid = 1'b0;
            m_pay = '0;
            m_rr = 0;
`ifdef ISSUE_SCHED_PERF_EN
            m_issue = '0;
            m_stall = '0;
`endif
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_pay = s_pay[g];
            m_rr = (g + 1) % N;
`ifdef ISSUE_SCHED_PERF_EN
            m_issue = m_issue + 1;
`endif
        end else begin
            if (fl || rdy) m_valid = 1'b0;
`ifdef ISSUE_SCHED_PERF_EN
            if (|v) m_stall = m_stall + 1;
`endif
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_slot = '0;
        bus.req_op = '0;
        bus.req_opcode = '0;
        bus.req_vj = '0;
        bus.req_vk = '0;
        bus.req_imm = '0;
        bus.req_rob_tag = '0;
        bus.fu_ready = 1'b0;
        // Reset with requests present: no grant may escape.
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        // Single request then drain.
        cycle(4'b0010, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        // All four requesting: rotating back-to-back grants.
        for (int i = 0; i < 6; i++) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
        // Stall three cycles, then release.
        for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        cycle(4'b1111, 1'b1, 1'b0, 1'b1);
        // Flush beats fu_ready, then station 2 is granted.
        cycle(4'b0100, 1'b1, 1'b1, 1'b1);
        cycle(4'b0100, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        // Reset during a stall with rr at 2.
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0, 1'b1);
        cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        // Ten grants, four stalls, a flush with no requests.
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(N'($urandom()), ($urandom() % 4) != 0, ($urandom() % 16) == 0, ($urandom() % 50) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
